// File: rtl/qpsk_ber_checker.sv
// qpsk_ber_checker
//   Bit-error-rate checker for the QPSK link. The transmitted reference stream is
//   run through a delay line. Every latency candidate is scored over one window,
//   and the checker locks to the candidate with the fewest errors. While locked it
//   counts compared bits and bit errors. Too many errors in one window start a new
//   sweep.
// Ports
//   clk           system clock, rising edge
//   i_reset       synchronous active-high reset
//   i_enable      run enable; low returns to idle and holds counters/latency
//   i_valid       sample strobe for i_ref_bit / i_rx_bit
//   i_ref_bit     transmitted reference bit
//   i_rx_bit      received, sliced bit
//   o_locked      latency found, counting active
//   o_latency     selected latency (valid samples)
//   o_bit_count   bits compared while locked (saturating)
//   o_err_count   bit errors while locked (saturating)
//   o_normal_led  {heartbeat, errors seen, locked, running}
module qpsk_ber_checker #(
  parameter int unsigned LAT_DEPTH = 512,
  parameter int unsigned WIN_LEN   = 511,
  parameter int unsigned LOSS_THR  = 128,
  parameter int unsigned CNT_W     = 64,
  parameter int unsigned HB_BIT    = 20
) (
  input  logic                         clk,
  input  logic                         i_reset,
  input  logic                         i_enable,
  input  logic                         i_valid,
  input  logic                         i_ref_bit,
  input  logic                         i_rx_bit,
  output logic                         o_locked,
  output logic [$clog2(LAT_DEPTH)-1:0] o_latency,
  output logic [CNT_W-1:0]             o_bit_count,
  output logic [CNT_W-1:0]             o_err_count,
  output logic [3:0]                   o_normal_led
);

  localparam int unsigned LW   = $clog2(LAT_DEPTH);
  localparam int unsigned WMAX = (WIN_LEN > LOSS_THR) ? WIN_LEN : LOSS_THR;
  // One spare bit so the all-ones "no best yet" value beats any real window score.
  localparam int unsigned EW   = $clog2(WMAX + 1) + 1;
  localparam int unsigned SW   = $clog2(WIN_LEN + 1);

  localparam logic [LW-1:0] LAT_LAST = LW'(LAT_DEPTH - 1);
  localparam logic [SW-1:0] WIN_LAST = SW'(WIN_LEN - 1);
  localparam logic [EW-1:0] LOSS     = EW'(LOSS_THR);

  typedef enum logic [1:0] {StIdle, StFill, StSearch, StCount} state_e;

  state_e               state;
  logic [LAT_DEPTH-2:0] dline;     // dline[k] = reference delayed by k+1 samples
  logic [LW-1:0]        cand;      // fill sample counter in StFill, candidate in StSearch
  logic [SW-1:0]        win_cnt;
  logic [EW-1:0]        win_err;
  logic [EW-1:0]        best_err;
  logic [LW-1:0]        best_lat;
  logic                 hit_v;     // registered compare result feeding the counters
  logic                 hit_err;

  logic [LAT_DEPTH-1:0] taps;
  logic                 tap_err;
  logic [EW-1:0]        win_err_nx;
  logic                 better;
  logic [LW-1:0]        pick_lat;
  logic                 shift;

  always_comb begin
    taps       = {dline, i_ref_bit};  // tap 0 is the current sample
    shift      = i_enable && i_valid && (state != StIdle);
    tap_err    = taps[(state == StCount) ? o_latency : cand] ^ i_rx_bit;
    win_err_nx = win_err + EW'(tap_err);
    better     = win_err_nx < best_err;  // strict: ties keep the earlier, lower latency
    pick_lat   = better ? cand : best_lat;
  end

  assign o_normal_led = {o_bit_count[HB_BIT], o_err_count != '0, o_locked, state != StIdle};

  // The delay line needs no reset: a full fill precedes every use of it.
  always_ff @(posedge clk) begin
    if (shift) begin
      dline <= taps[LAT_DEPTH-2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state       <= StIdle;
      cand        <= '0;
      win_cnt     <= '0;
      win_err     <= '0;
      best_err    <= '1;
      best_lat    <= '0;
      hit_v       <= 1'b0;
      hit_err     <= 1'b0;
      o_locked    <= 1'b0;
      o_latency   <= '0;
      o_bit_count <= '0;
      o_err_count <= '0;
    end else begin
      hit_v   <= 1'b0;
      hit_err <= 1'b0;

      if (state == StIdle && i_enable) begin
        o_bit_count <= '0;
        o_err_count <= '0;
      end else if (hit_v) begin
        if (o_bit_count != '1) o_bit_count <= o_bit_count + CNT_W'(1);
        if (hit_err && o_err_count != '1) o_err_count <= o_err_count + CNT_W'(1);
      end

      if (!i_enable) begin
        state    <= StIdle;
        o_locked <= 1'b0;
      end else begin
        unique case (state)
          StIdle: begin
            state <= StFill;
            cand  <= '0;
          end
          StFill: begin
            if (i_valid) begin
              cand <= cand + LW'(1);  // wraps to candidate 0 on the last fill sample
              if (cand == LAT_LAST) begin
                state    <= StSearch;
                win_cnt  <= '0;
                win_err  <= '0;
                best_err <= '1;
                best_lat <= '0;
              end
            end
          end
          StSearch: begin
            if (i_valid) begin
              if (win_cnt == WIN_LAST) begin
                win_cnt <= '0;
                win_err <= '0;
                cand    <= cand + LW'(1);
                if (better) begin
                  best_err <= win_err_nx;
                  best_lat <= cand;
                end
                if (cand == LAT_LAST) begin
                  state     <= StCount;
                  o_locked  <= 1'b1;
                  o_latency <= pick_lat;
                end
              end else begin
                win_cnt <= win_cnt + SW'(1);
                win_err <= win_err_nx;
              end
            end
          end
          StCount: begin
            if (i_valid) begin
              hit_v   <= 1'b1;
              hit_err <= tap_err;
              if (win_err_nx == LOSS) begin
                state    <= StSearch;
                o_locked <= 1'b0;
                cand     <= '0;
                win_cnt  <= '0;
                win_err  <= '0;
                best_err <= '1;
                best_lat <= '0;
              end else if (win_cnt == WIN_LAST) begin
                win_cnt <= '0;
                win_err <= '0;
              end else begin
                win_cnt <= win_cnt + SW'(1);
                win_err <= win_err_nx;
              end
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qpsk_ber_checker.sv
// Testbench for qpsk_ber_checker. Two instances share one stimulus stream:
//   dut_a: 16 candidates, window 31, loss threshold 8, 16-bit counters
//   dut_b: same sweep, loss threshold above the window (never unlocks), 8-bit counters
// Every cycle a reference model pushes the expected outputs; a monitor pops and
// compares them one cycle later. Directed checks cover the key scenario results.
module tb_qpsk_ber_checker;

  localparam int LD = 16;
  localparam int WL = 31;
  localparam int M_IDLE = 0, M_FILL = 1, M_SRCH = 2, M_CNT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, vld, ref_b, rx_b;
  logic        a_locked, b_locked;
  logic [3:0]  a_lat, b_lat, a_led, b_led;
  logic [15:0] a_bits, a_errs;
  logic [7:0]  b_bits, b_errs;

  qpsk_ber_checker #(.LAT_DEPTH(LD), .WIN_LEN(WL), .LOSS_THR(8), .CNT_W(16), .HB_BIT(6)) dut_a (
    .clk(clk), .i_reset(rst), .i_enable(en), .i_valid(vld), .i_ref_bit(ref_b),
    .i_rx_bit(rx_b), .o_locked(a_locked), .o_latency(a_lat), .o_bit_count(a_bits),
    .o_err_count(a_errs), .o_normal_led(a_led)
  );

  qpsk_ber_checker #(.LAT_DEPTH(LD), .WIN_LEN(WL), .LOSS_THR(64), .CNT_W(8), .HB_BIT(3)) dut_b (
    .clk(clk), .i_reset(rst), .i_enable(en), .i_valid(vld), .i_ref_bit(ref_b),
    .i_rx_bit(rx_b), .o_locked(b_locked), .o_latency(b_lat), .o_bit_count(b_bits),
    .o_err_count(b_errs), .o_normal_led(b_led)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit     locked;
    int     lat;
    longint bitc;
    longint errc;
    int     led;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int     loss_thr [2] = '{8, 64};
  int     cnt_w    [2] = '{16, 8};
  int     hb_bit   [2] = '{6, 3};
  int     md       [2];
  int     fill_n   [2];
  int     srch_n   [2];
  int     win_n    [2];
  int     win_e    [2];
  int     lat_m    [2];
  int     sweep_err[2][LD];
  longint bitc     [2];
  longint errc     [2];
  bit     pend_v   [2];
  bit     pend_e   [2];
  bit     hist     [2][64];  // reference samples seen while running, ring buffer
  int     hist_n   [2];

  function automatic bit tap(input int i, input int l);
    return hist[i][(hist_n[i] - 1 - l) & 63];
  endfunction

  function automatic int best_of(input int i);
    int b = 0;
    for (int c = 1; c < LD; c++) if (sweep_err[i][c] < sweep_err[i][b]) b = c;
    return b;
  endfunction

  task automatic start_sweep(input int i);
    srch_n[i] = 0;
    for (int c = 0; c < LD; c++) sweep_err[i][c] = 0;
  endtask

  task automatic model(input int i, input bit r, input bit e, input bit v,
                       input bit rb, input bit xb);
    longint cmax;
    bit     nv, ne;
    int     c;
    exp_t   x;
    cmax = (longint'(1) << cnt_w[i]) - 1;
    nv = 1'b0;
    ne = 1'b0;
    if (r) begin
      md[i] = M_IDLE; lat_m[i] = 0; bitc[i] = 0; errc[i] = 0;
    end else begin
      // counters reflect the compare from the previous valid sample
      if (md[i] == M_IDLE && e) begin
        bitc[i] = 0; errc[i] = 0;
      end else if (pend_v[i]) begin
        if (bitc[i] < cmax) bitc[i]++;
        if (pend_e[i] && errc[i] < cmax) errc[i]++;
      end
      if (!e) md[i] = M_IDLE;
      else if (md[i] == M_IDLE) begin
        md[i] = M_FILL; fill_n[i] = 0;
      end else if (v) begin
        hist[i][hist_n[i] & 63] = rb;
        hist_n[i]++;
        case (md[i])
          M_FILL: begin
            fill_n[i]++;
            if (fill_n[i] == LD) begin md[i] = M_SRCH; start_sweep(i); end
          end
          M_SRCH: begin
            c = srch_n[i] / WL;
            if (tap(i, c) != xb) sweep_err[i][c]++;
            srch_n[i]++;
            if (srch_n[i] == LD * WL) begin
              lat_m[i] = best_of(i); md[i] = M_CNT; win_n[i] = 0; win_e[i] = 0;
            end
          end
          default: begin
            ne = (tap(i, lat_m[i]) != xb);
            nv = 1'b1;
            win_n[i]++;
            win_e[i] += int'(ne);
            if (win_e[i] == loss_thr[i]) begin md[i] = M_SRCH; start_sweep(i); end
            else if (win_n[i] == WL) begin win_n[i] = 0; win_e[i] = 0; end
          end
        endcase
      end
    end
    pend_v[i] = nv;
    pend_e[i] = ne;
    x.locked = (md[i] == M_CNT);
    x.lat    = lat_m[i];
    x.bitc   = bitc[i];
    x.errc   = errc[i];
    x.led    = (int'((bitc[i] >> hb_bit[i]) & 1) << 3) | ((errc[i] != 0) ? 4 : 0) |
               (x.locked ? 2 : 0) | ((md[i] != M_IDLE) ? 1 : 0);
    if (i == 0) qa.push_back(x);
    else qb.push_back(x);
  endtask

  // ---------------- monitor ----------------
  always begin
    exp_t ea, eb;
    @(posedge clk);
    #1;
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      chk("a_locked", a_locked, ea.locked);
      chk("a_latency", a_lat, ea.lat);
      chk("a_bit_count", a_bits, ea.bitc);
      chk("a_err_count", a_errs, ea.errc);
      chk("a_led", a_led, ea.led);
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      chk("b_locked", b_locked, eb.locked);
      chk("b_latency", b_lat, eb.lat);
      chk("b_bit_count", b_bits, eb.bitc);
      chk("b_err_count", b_errs, eb.errc);
      chk("b_led", b_led, eb.led);
    end
  end

  // ---------------- stimulus ----------------
  logic [8:0] prbs = 9'h1FF;  // PRBS9, x^9 + x^5 + 1
  bit         chan[64];
  int         chan_n = 0;
  int         delay  = 5;

  function automatic bit pick_v(input int duty);
    return ($urandom_range(duty - 1) == 0);
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit r, input bit e, input bit v, input bit flip);
    bit rb, xb;
    if (v) begin
      rb = prbs[8] ^ prbs[4];
      prbs = {prbs[7:0], rb};
      chan[chan_n & 63] = rb;
      chan_n++;
      xb = (chan_n - 1 - delay >= 0) ? chan[(chan_n - 1 - delay) & 63] : 1'b0;
      xb = xb ^ flip;
    end else begin
      rb = 1'($urandom_range(1));
      xb = 1'($urandom_range(1));
    end
    rst = r; en = e; vld = v; ref_b = rb; rx_b = xb;
    model(0, r, e, v, rb, xb);
    model(1, r, e, v, rb, xb);
    @(negedge clk);
  endtask

  task automatic run_valid(input int n, input int duty, input bit flip_all);
    int got = 0;
    int cyc = 0;
    bit v;
    while (got < n && cyc < n * duty * 20) begin
      v = pick_v(duty);
      step(1'b0, 1'b1, v, flip_all);
      got += int'(v);
      cyc++;
    end
    chk("valid_budget", got, n);
  endtask

  task automatic run_until_lock(input bit want, input int duty, input int bound,
                                input string nm);
    int c = 0;
    while (a_locked !== want && c < bound) begin
      step(1'b0, 1'b1, pick_v(duty), 1'b0);
      c++;
    end
    chk(nm, a_locked, want);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; vld = 1'b0; ref_b = 1'b0; rx_b = 1'b0;
    @(negedge clk);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset_led", a_led, 0);

    // back-to-back lock on channel delay 5
    step(1'b0, 1'b1, 1'b1, 1'b0);
    run_until_lock(1'b1, 1, 700, "lock_b2b");
    chk("lock_b2b_latency_a", a_lat, 5);
    chk("lock_b2b_latency_b", b_lat, 5);
    run_valid(1000, 1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("bits_1000", a_bits, 1000);
    chk("errs_0", a_errs, 0);

    // every 100th received bit flipped
    for (int m = 1; m <= 1000; m++) step(1'b0, 1'b1, 1'b1, (m % 100) == 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("errs_10", a_errs, 10);
    chk("bits_2000", a_bits, 2000);
    chk("led_err", a_led[2], 1);
    chk("b_bits_saturated", b_bits, 255);

    // reset mid-count
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst_locked", a_locked, 0);
    chk("rst_latency", a_lat, 0);
    chk("rst_bits", a_bits, 0);
    chk("rst_errs", a_errs, 0);
    chk("rst_led", a_led, 0);

    // 1-in-4 gaps; drop enable mid-search, then a full fresh sweep
    run_valid(60, 4, 1'b0);
    repeat (3) step(1'b0, 1'b0, pick_v(4), 1'b0);
    chk("drop_led0_a", a_led[0], 0);
    chk("drop_led0_b", b_led[0], 0);
    run_until_lock(1'b1, 4, 5000, "lock_gapped");
    chk("lock_gapped_latency", a_lat, 5);
    run_valid(100, 4, 1'b0);

    // channel delay moves to 9: dut_a unlocks and re-locks, dut_b stays locked
    delay = 9;
    run_until_lock(1'b0, 2, 300, "loss_of_lock");
    chk("loss_b_still_locked", b_locked, 1);
    run_until_lock(1'b1, 2, 3000, "relock");
    chk("relock_latency", a_lat, 9);

    // every bit wrong: dut_b counters pin at all-ones
    delay = 5;
    run_valid(600, 1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("sat_bits", b_bits, 255);
    chk("sat_errs", b_errs, 255);
    step(1'b0, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qpsk_ber_checker.md
# qpsk_ber_checker

Bit-error-rate checker that consumes the transmitted reference bit stream and the receiver's sliced bit stream inside the QPSK communication system, one bit per valid strobe. It finds the unknown TX-to-RX latency by sweeping a delay line over a range of candidates, locks to the best candidate, and accumulates bit and error counts. Its status drives the 4-bit LED bus that is exported to the board LEDs and probed by the VIO/ILA.

## Interface
Parameters:
- LAT_DEPTH, 512: number of latency candidates (0..LAT_DEPTH-1); power of two.
- WIN_LEN, 511: valid samples per evaluation window.
- LOSS_THR, 128: errors in one window, while locked, that force re-search.
- CNT_W, 64: width of bit and error counters.
- HB_BIT, 20: bit_count bit driving the heartbeat LED.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  run enable (switch/VIO).
- i_valid  in  1  one-cycle strobe; i_ref_bit and i_rx_bit are sampled only when high.
- i_ref_bit  in  1  transmitted bit.
- i_rx_bit  in  1  received, sliced bit.
- o_locked  out  1  latency found, counting active.
- o_latency  out  log2(LAT_DEPTH)  selected latency.
- o_bit_count  out  CNT_W  compared bits while locked.
- o_err_count  out  CNT_W  errors while locked.
- o_normal_led  out  4  {heartbeat, err_count!=0, o_locked, state!=IDLE} (bit 3..0).

## Operation
- Delay line: LAT_DEPTH-deep shift register of i_ref_bit, shifted on every i_valid in all states except IDLE. Tap L = reference delayed by L valid samples.
- States: IDLE, FILL, SEARCH, COUNT.
- IDLE: nothing shifts or counts; on i_enable=1 -> FILL, and bit/error counters clear to 0.
- FILL: counts LAT_DEPTH valid samples, then -> SEARCH with candidate=0.
- SEARCH: for the current candidate, accumulate tap(candidate) XOR i_rx_bit over WIN_LEN valid samples. At window end, if errors < best_err, store best_err/best_lat; ties keep the lower latency. Candidate increments; after candidate LAT_DEPTH-1 finishes, o_latency<=best_lat -> COUNT. best_err initialises to all-ones at entry to SEARCH.
- COUNT: on each i_valid, bit_count+1, err_count+1 if tap(o_latency) != i_rx_bit. Both counters saturate at all-ones, with no wrap; err_count never exceeds bit_count. A window error counter runs over WIN_LEN samples. If it reaches LOSS_THR, then -> SEARCH, o_locked falls, and the counters hold their values without clearing.
- i_enable=0 in any state -> IDLE next cycle; counters and o_latency hold.
- i_valid=0 cycles are ignored entirely, with no progress.

## Timing
- Reset, and any cycle with i_reset high: state IDLE; o_locked=0, o_latency=0, counters=0, o_normal_led=4'b0000. Reset mid-search or mid-count aborts immediately.
- Counter latency: the i_valid sample at edge n is reflected in o_bit_count/o_err_count after edge n+1 (one register stage for the XOR).
- The sample that completes a window belongs to that window. The first COUNT sample is the next i_valid after the last SEARCH sample.
- o_locked rises on the same edge the state enters COUNT and falls on the same edge it leaves COUNT.
- Minimum lock time after enable: LAT_DEPTH + LAT_DEPTH*WIN_LEN valid samples plus 2 cycles.
- i_valid may be asserted every cycle (back-to-back) with no loss.

## Test plan
- Reset: assert i_reset for 3 cycles mid-COUNT -> all outputs zero next cycle and state IDLE.
- Lock: LAT_DEPTH=16, WIN_LEN=31, PRBS9 ref, rx = ref delayed 5 samples, i_valid every cycle -> o_locked after 16+16*31 samples, o_latency=5; after 1000 more samples bit_count=1000, err_count=0.
- Errors: same setup, flip every 100th rx bit after lock -> err_count = floor(N/100) ±0 at check points; o_normal_led[2]=1.
- Loss of lock: after lock, change channel delay to 9 -> within one window o_locked=0; re-lock with o_latency=9; counters not cleared.
- Gaps/enable: i_valid 1-in-4 duty -> same results as the back-to-back case. Drop i_enable mid-SEARCH -> IDLE, with LED[0]=0. Re-enable -> counters cleared and full sweep repeats.
- Saturation: CNT_W=8, force all-error rx after lock -> both counters stick at 255.
